// File: rtl/cache_pkg.sv
// Shared types and helpers for the 2-way cache controller.
package cache_pkg;

  localparam int unsigned WPL_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    ALLOC,
    DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_lru_array.sv
// Per-set LRU bit (value = way to evict next): async clear, one write port, combinational read.
module cache_lru_array #(
  parameter int unsigned INDEX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic               wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic               rdata
);

  localparam int unsigned DEPTH = 2 ** INDEX_W;

  logic [DEPTH-1:0] lru_q, lru_d;

  always_comb begin
    lru_d = lru_q;
    if (we) lru_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lru_q <= '0;
    else     lru_q <= lru_d;
  end

  assign rdata = lru_q[raddr];

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative cache controller with per-set LRU, pipelined write-back and fill.
// Optional CACHE_CTRL_ERR_EN: error inputs abort to IDLE with err/done pulse.
module cache_ctrl_2way
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WPL_DEFAULT,
  parameter int unsigned MEM_BANKS      = 4,
  parameter int unsigned MEM_LAT        = 2,
  parameter int unsigned INDEX_W        = 8,
  localparam int unsigned WW            = clog2(WORDS_PER_LINE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [INDEX_W-1:0]   index,
  input  logic [1:0]           hit,
  input  logic [1:0]           valid,
  input  logic [1:0]           dirty,
  input  logic                 cache_err,
  input  logic [MEM_BANKS-1:0] mem_busy,
  input  logic                 mem_err,
  output logic                 comp,
  output logic                 way_sel,
  output logic                 cache_wr,
  output logic [WW-1:0]        cache_word,
  output logic [WW-1:0]        mem_word,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 victim_tag,
  output logic                 stall,
  output logic                 done,
  output logic                 cache_hit,
  output logic                 err
);

  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

  state_e                     state_q, state_d;
  logic                       victim_q, victim_d;
  logic                       is_wr_q, is_wr_d;
  logic [WW-1:0]              cnt_q, cnt_d;
  logic                       issued_all_q, issued_all_d;
  logic [MEM_LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [MEM_LAT-1:0][WW-1:0] pipe_word_q, pipe_word_d;
  logic                       err_q, err_d;

  logic       lru_we, lru_wdata, lru_rdata;
  logic [1:0] hv;
  logic       miss_victim, bank_busy, issue, err_in;

`ifdef CACHE_CTRL_ERR_EN
  assign err_in = cache_err | mem_err;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = cache_err ^ mem_err;
  assign err_in = 1'b0;
`endif

  cache_lru_array #(.INDEX_W(INDEX_W)) u_lru (
    .clk   (clk),
    .rst   (rst),
    .we    (lru_we),
    .waddr (index),
    .wdata (lru_wdata),
    .raddr (index),
    .rdata (lru_rdata)
  );

  always_comb begin
    hv = hit & valid;
    if (!valid[0])      miss_victim = 1'b0;
    else if (!valid[1]) miss_victim = 1'b1;
    else                miss_victim = lru_rdata;

    bank_busy = 1'b0;
    for (int unsigned b = 0; b < MEM_BANKS; b++)
      if ((32'(cnt_q) % MEM_BANKS) == b) bank_busy = mem_busy[b];

    state_d      = state_q;
    victim_d     = victim_q;
    is_wr_d      = is_wr_q;
    cnt_d        = cnt_q;
    issued_all_d = issued_all_q;
    err_d        = 1'b0;
    lru_we       = 1'b0;
    lru_wdata    = 1'b0;
    issue        = 1'b0;
    comp         = 1'b0;
    way_sel      = 1'b0;
    cache_wr     = 1'b0;
    cache_word   = '0;
    mem_word     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    victim_tag   = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    cache_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        comp = 1'b1;
        if (rd | wr) begin
          if (|hv) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            way_sel   = ~hv[0];
            cache_wr  = wr;
            lru_we    = 1'b1;
            lru_wdata = hv[0];
          end else begin
            victim_d     = miss_victim;
            is_wr_d      = wr;
            cnt_d        = '0;
            issued_all_d = 1'b0;
            state_d      = (valid[miss_victim] & dirty[miss_victim]) ? WB : FILL;
          end
        end
      end
      WB: begin
        stall      = 1'b1;
        victim_tag = 1'b1;
        way_sel    = victim_q;
        cache_word = cnt_q;
        mem_word   = cnt_q;
        if (!bank_busy) begin
          mem_wr = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        way_sel  = victim_q;
        mem_word = cnt_q;
        // The counter parks on the last word once all reads are out; returns drain via the pipe.
        if (!issued_all_q && !bank_busy) begin
          issue  = 1'b1;
          mem_rd = 1'b1;
          if (cnt_q == LAST_WORD) issued_all_d = 1'b1;
          else                    cnt_d = cnt_q + 1'b1;
        end
        if (pipe_vld_q[MEM_LAT-1]) begin
          cache_wr   = 1'b1;
          cache_word = pipe_word_q[MEM_LAT-1];
          if (pipe_word_q[MEM_LAT-1] == LAST_WORD) begin
            cnt_d        = '0;
            issued_all_d = 1'b0;
            state_d      = ALLOC;
          end
        end
      end
      ALLOC: begin
        comp     = 1'b1;
        stall    = 1'b1;
        way_sel  = victim_q;
        cache_wr = is_wr_q;
        state_d  = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stall     = 1'b1;
        lru_we    = 1'b1;
        lru_wdata = ~victim_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_in) begin
      state_d = IDLE;
      err_d   = 1'b1;
      lru_we  = 1'b0;
    end
    done = done | err_q;
    err  = err_q;

    pipe_vld_d  = '0;
    pipe_word_d = '0;
    if (state_d == FILL) begin
      for (int unsigned i = MEM_LAT - 1; i > 0; i--) begin
        pipe_vld_d[i]  = pipe_vld_q[i-1];
        pipe_word_d[i] = pipe_word_q[i-1];
      end
      pipe_vld_d[0]  = issue;
      pipe_word_d[0] = cnt_q;
    end

    // IDLE decodes comp=1, so outputs are masked to keep them all low while reset is held.
    if (rst) begin
      {comp, way_sel, cache_wr, mem_rd, mem_wr, victim_tag, stall, done, cache_hit, err} = '0;
      cache_word = '0;
      mem_word   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= 1'b0;
      is_wr_q      <= 1'b0;
      cnt_q        <= '0;
      issued_all_q <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_word_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      issued_all_q <= issued_all_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_word_q  <= pipe_word_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way: directed scenarios plus randomized requests vs a timeline model.
module tb_cache_ctrl_2way;

  localparam int unsigned WPL   = 4;
  localparam int unsigned BANKS = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned IW    = 8;
  localparam int unsigned WW    = 2;
  localparam int          NCYC  = 64;
`ifdef CACHE_CTRL_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rd, wr;
  logic [IW-1:0]    index;
  logic [1:0]       hit, valid, dirty;
  logic             cache_err, mem_err;
  logic [BANKS-1:0] mem_busy;
  logic             comp, way_sel, cache_wr, mem_rd, mem_wr, victim_tag;
  logic             stall, done, cache_hit, err;
  logic [WW-1:0]    cache_word, mem_word;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       cur_name;
  int          cur_k;

  bit               lru_m [256];
  logic [BANKS-1:0] busy_pat [NCYC];
  bit               exp_mwr [NCYC];
  bit               exp_mrd [NCYC];
  bit               exp_fill [NCYC];
  logic [WW-1:0]    exp_mword [NCYC];
  logic [WW-1:0]    exp_fword [NCYC];

  always #5 clk = ~clk;

  cache_ctrl_2way #(
    .WORDS_PER_LINE (WPL),
    .MEM_BANKS      (BANKS),
    .MEM_LAT        (LAT),
    .INDEX_W        (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .wr         (wr),
    .index      (index),
    .hit        (hit),
    .valid      (valid),
    .dirty      (dirty),
    .cache_err  (cache_err),
    .mem_busy   (mem_busy),
    .mem_err    (mem_err),
    .comp       (comp),
    .way_sel    (way_sel),
    .cache_wr   (cache_wr),
    .cache_word (cache_word),
    .mem_word   (mem_word),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .victim_tag (victim_tag),
    .stall      (stall),
    .done       (done),
    .cache_hit  (cache_hit),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s k=%0d: observed %0h expected %0h", cur_name, tag, cur_k, obs, exp);
    end
  endtask

  function automatic void clear_busy();
    for (int i = 0; i < NCYC; i++) busy_pat[i] = '0;
  endfunction

  // Timeline of a miss: each word issues at the first free-bank cycle after the previous one.
  function automatic int build_model(input bit miss, input bit wb);
    int t, last;
    for (int i = 0; i < NCYC; i++) begin
      exp_mwr[i] = 0; exp_mrd[i] = 0; exp_fill[i] = 0;
      exp_mword[i] = '0; exp_fword[i] = '0;
    end
    if (!miss) return 0;
    t = 1;
    last = 0;
    if (wb) begin
      for (int w = 0; w < WPL; w++) begin
        while (busy_pat[t][w % BANKS]) t++;
        exp_mwr[t] = 1; exp_mword[t] = WW'(w);
        t++;
      end
    end
    for (int w = 0; w < WPL; w++) begin
      while (busy_pat[t][w % BANKS]) t++;
      exp_mrd[t] = 1; exp_mword[t] = WW'(w);
      exp_fill[t + LAT] = 1; exp_fword[t + LAT] = WW'(w);
      last = t + LAT;
      t++;
    end
    return last + 2;
  endfunction

  task automatic do_req(input string name, input logic r, input logic w, input logic [7:0] idx,
                        input logic [1:0] h, input logic [1:0] v, input logic [1:0] d,
                        input int err_k, input int rst_k);
    logic [1:0] hv;
    bit         is_hit, wb, erred;
    logic       vic, hway;
    int         done_k, alloc_k;
    cur_name = name;
    hv     = h & v;
    is_hit = (hv != 2'b00);
    hway   = hv[0] ? 1'b0 : 1'b1;
    if (!v[0])      vic = 1'b0;
    else if (!v[1]) vic = 1'b1;
    else            vic = lru_m[idx];
    wb      = !is_hit && v[vic] && d[vic];
    done_k  = build_model(!is_hit, wb);
    alloc_k = is_hit ? -1 : done_k - 1;
    erred   = ERR_BUILD && !is_hit && err_k >= 0;
    if (erred) begin
      done_k  = err_k + 1;
      alloc_k = -1;
    end
    rd = r; wr = w; index = idx; hit = h; valid = v; dirty = d;
    for (int k = 0; k < NCYC; k++) begin
      cur_k    = k;
      mem_busy = busy_pat[k];
      mem_err  = (k == err_k);
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        chk("rst_outs", {comp, way_sel, cache_wr, mem_rd, mem_wr, victim_tag, stall, done,
                         cache_hit, err, cache_word, mem_word}, '0);
        @(posedge clk); #1;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; mem_busy = '0; mem_err = 1'b0;
        #2;
        chk("post_rst_wr", cache_wr, 0);
        chk("post_rst_stall", stall, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) lru_m[i] = 0;
        return;
      end
      #2;
      if (erred && k == done_k) begin
        chk("err_flag", err, 1);
        chk("err_done", done, 1);
        chk("err_stall", stall, 0);
        chk("err_hit", cache_hit, 0);
      end else begin
        chk("stall", stall, k != 0);
        chk("done", done, k == done_k);
        chk("err", err, 0);
        chk("mem_wr", mem_wr, exp_mwr[k]);
        chk("mem_rd", mem_rd, exp_mrd[k]);
        if (exp_mwr[k] || exp_mrd[k]) begin
          chk("mem_word", mem_word, exp_mword[k]);
          chk("victim_tag", victim_tag, exp_mwr[k]);
        end
        if (exp_mwr[k]) chk("wb_way", way_sel, vic);
        chk("comp", comp, (k == 0) || (k == alloc_k));
        if (is_hit) begin
          chk("hit_wr", cache_wr, w);
          chk("hit_way", way_sel, hway);
        end else if (k == alloc_k) begin
          chk("alloc_wr", cache_wr, w);
          chk("alloc_way", way_sel, vic);
        end else begin
          chk("fill_wr", cache_wr, exp_fill[k]);
          if (exp_fill[k]) begin
            chk("fill_word", cache_word, exp_fword[k]);
            chk("fill_way", way_sel, vic);
          end
        end
        if (k == done_k) chk("cache_hit", cache_hit, is_hit);
      end
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0; mem_err = 1'b0;
      if (k == done_k) break;
    end
    mem_busy = '0;
    if (!erred) lru_m[idx] = is_hit ? ~hway : ~vic;
  endtask

  initial begin
    rst = 1'b1; rd = 0; wr = 0; index = '0; hit = '0; valid = '0; dirty = '0;
    cache_err = 0; mem_err = 0; mem_busy = '0;
    for (int i = 0; i < 256; i++) lru_m[i] = 0;
    clear_busy();
    cur_name = "reset"; cur_k = 0;
    #2;
    chk("rst_outs", {comp, way_sel, cache_wr, mem_rd, mem_wr, victim_tag, stall, done,
                     cache_hit, err, cache_word, mem_word}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("idle_comp", comp, 1);
    chk("idle_stall", stall, 0);
    @(posedge clk); #1;

    // clean read miss, both ways invalid: way 0 filled, done at cycle 8
    do_req("rd_miss_inv", 1, 0, 8'h10, 2'b00, 2'b00, 2'b00, -1, -1);
    // read hit on way 1, then a dirty write miss on the same set must evict way 0
    do_req("rd_hit_w1", 1, 0, 8'h20, 2'b10, 2'b11, 2'b00, -1, -1);
    do_req("wr_miss_dirty", 0, 1, 8'h20, 2'b00, 2'b11, 2'b01, -1, -1);
    // bank 2 busy for three cycles while word 2 is due
    busy_pat[3] = 4'b0100; busy_pat[4] = 4'b0100; busy_pat[5] = 4'b0100;
    do_req("fill_busy2", 1, 0, 8'h30, 2'b00, 2'b00, 2'b00, -1, -1);
    clear_busy();
    // rd&wr together is a write
    do_req("rdwr_hit", 1, 1, 8'h31, 2'b01, 2'b01, 2'b00, -1, -1);
    // LRU points at way 1, reset mid-fill, then the set must miss and evict way 0
    do_req("hit_w0", 1, 0, 8'h40, 2'b01, 2'b11, 2'b00, -1, -1);
    do_req("miss_rst", 1, 0, 8'h40, 2'b00, 2'b11, 2'b00, -1, 4);
    do_req("miss_after_rst", 1, 0, 8'h40, 2'b00, 2'b11, 2'b00, -1, -1);
    // memory error pulse during write-back
    do_req("err_in_wb", 0, 1, 8'h50, 2'b00, 2'b11, 2'b11, 2, -1);

    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      clear_busy();
      for (int k = 1; k < 25; k++) busy_pat[k] = BANKS'($urandom) & BANKS'($urandom);
      op = $urandom_range(0, 2);
      do_req($sformatf("rand%0d", n), op != 1, op != 0, 8'h80 + 8'($urandom_range(0, 7)),
             2'($urandom), 2'($urandom), 2'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
